tri_lane_dispatcher: RTL and testbench

TRI_LANE_DISPATCHER -- requirements
Module: tri_lane_dispatcher

---
 rtl/pipe_pkg.sv | 8 +
 rtl/lane_order_fifo.sv | 35 +++
 rtl/tri_lane_dispatcher.sv | 82 ++++++++
 tb/tb_tri_lane_dispatcher.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and helpers for the triangle lane dispatcher
package pipe_pkg;
  typedef enum logic {RUN, DRAIN} state_t;
  typedef logic [2:0] lane_id_t;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lane_order_fifo.sv
// lane_order_fifo: registered FIFO recording the lane ID of every issued triangle
module lane_order_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  // pointers carry an extra wrap bit so full and empty are distinguishable
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (push && !full) r_wr <= r_wr + 1'b1;
      if (pop && !empty) r_rd <= r_rd + 1'b1;
    end
  // storage needs no reset: only entries between the pointers are ever read
  always_ff @(posedge clk)
    if (push && !full) r_mem[r_wr[AW-1:0]] <= din;
  assign count = r_wr - r_rd;
  assign empty = r_wr == r_rd;
  assign full  = count == (AW+1)'(DEPTH);
  assign dout  = r_mem[r_rd[AW-1:0]];
endmodule

// File: rtl/tri_lane_dispatcher.sv
// tri_lane_dispatcher: round-robin issue of triangles to free lanes with in-order result merge
module tri_lane_dispatcher
  import pipe_pkg::*;
#(
  parameter int N_LANES   = 2,
  parameter int DATA_W    = 288,
  parameter int ORD_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_data,
  output logic [N_LANES-1:0]         lane_valid,
  input  logic [N_LANES-1:0]         lane_ready,
  output logic [DATA_W-1:0]          lane_data,
  input  logic [N_LANES-1:0]         res_valid,
  output logic [N_LANES-1:0]         res_ready,
  input  logic [N_LANES*DATA_W-1:0]  res_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_W-1:0]          m_data,
  input  logic                       flush,
  output logic                       flush_done,
  output logic [$clog2(ORD_DEPTH):0] in_flight,
  output logic                       busy,
  output logic [31:0]                tri_count
);
  localparam int ID_W = id_w(N_LANES);
  state_t r_state, w_next;
  logic [ID_W-1:0] r_rr_ptr, w_sel, w_head;
  logic [N_LANES-1:0] w_rot;
  logic r_flush_done, w_full, w_empty, w_issue, w_pop;
  logic [31:0] r_tri_count;
  assign w_rot = N_LANES'({lane_ready, lane_ready} >> r_rr_ptr);
  // first ready lane at or after the round-robin pointer, wrapping around
  always_comb begin
    w_sel = r_rr_ptr;
    for (int k = N_LANES - 1; k >= 0; k--)
      if (w_rot[k]) w_sel = ID_W'((32'(r_rr_ptr) + 32'(k)) % N_LANES);
  end
  assign s_ready    = |lane_ready && !w_full && r_state == RUN;
  assign w_issue    = s_valid && s_ready;
  assign lane_valid = N_LANES'(w_issue) << w_sel;
  assign lane_data  = s_data;
  assign m_valid    = !w_empty && res_valid[w_head];
  assign m_data     = res_data[w_head*DATA_W +: DATA_W];
  assign res_ready  = N_LANES'(m_ready && !w_empty) << w_head;
  assign w_pop      = m_valid && m_ready;
  assign busy       = !w_empty || r_state == DRAIN;
  assign flush_done = r_flush_done;
  assign tri_count  = r_tri_count;
  lane_order_fifo #(.WIDTH(ID_W), .DEPTH(ORD_DEPTH)) u_ord (
    .clk   (clk),
    .rst   (rst),
    .push  (w_issue),
    .pop   (w_pop),
    .din   (w_sel),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (in_flight)
  );
  // flush starts a drain; the drain ends once every issued triangle has been emitted
  always_comb begin
    w_next = r_state;
    w_next = (r_state == RUN) ? (flush ? DRAIN : RUN) : (w_empty ? RUN : DRAIN);
  end
  // state, round-robin pointer, drain-done pulse and emitted-triangle count
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state      <= RUN;
      r_rr_ptr     <= '0;
      r_flush_done <= 1'b0;
      r_tri_count  <= '0;
    end else begin
      r_state      <= w_next;
      r_flush_done <= r_state == DRAIN && w_empty;
      if (w_issue) r_rr_ptr <= ID_W'((32'(w_sel) + 32'd1) % N_LANES);
      if (w_pop) r_tri_count <= r_tri_count + 32'd1;
    end
endmodule

// File: tb/tb_tri_lane_dispatcher.sv
// tb_tri_lane_dispatcher: directed vectors and ordering scoreboard for tri_lane_dispatcher
module tb_tri_lane_dispatcher;
  localparam logic [31:0] TA = 32'hAAAA0001, TB = 32'hBBBB0002, TC = 32'hCCCC0003, TD = 32'hDDDD0004;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic s_valid2, s_ready2, m_valid2, m_ready2, flush2, flush_done2, busy2;
  logic [31:0] s_data2, lane_data2, m_data2, tri_count2;
  logic [1:0] lane_valid2, lane_ready2, res_valid2, res_ready2;
  logic [63:0] res_data2;
  logic [2:0] in_flight2;

  logic s_valid4, s_ready4, m_valid4, m_ready4, flush4, flush_done4, busy4;
  logic [31:0] s_data4, lane_data4, m_data4, tri_count4;
  logic [3:0] lane_valid4, lane_ready4, res_valid4, res_ready4;
  logic [127:0] res_data4;
  logic [4:0] in_flight4;

  tri_lane_dispatcher #(.N_LANES(2), .DATA_W(32), .ORD_DEPTH(4)) d2 (
    .clk(clk), .rst(rst), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
    .lane_valid(lane_valid2), .lane_ready(lane_ready2), .lane_data(lane_data2),
    .res_valid(res_valid2), .res_ready(res_ready2), .res_data(res_data2),
    .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2),
    .flush(flush2), .flush_done(flush_done2), .in_flight(in_flight2), .busy(busy2), .tri_count(tri_count2));

  tri_lane_dispatcher #(.N_LANES(4), .DATA_W(32), .ORD_DEPTH(16)) d4 (
    .clk(clk), .rst(rst), .s_valid(s_valid4), .s_ready(s_ready4), .s_data(s_data4),
    .lane_valid(lane_valid4), .lane_ready(lane_ready4), .lane_data(lane_data4),
    .res_valid(res_valid4), .res_ready(res_ready4), .res_data(res_data4),
    .m_valid(m_valid4), .m_ready(m_ready4), .m_data(m_data4),
    .flush(flush4), .flush_done(flush_done4), .in_flight(in_flight4), .busy(busy4), .tri_count(tri_count4));

  typedef struct packed {
    logic [3:0] rdy;
    logic       sv;
    logic [3:0] lv;
    logic       sr;
    logic [4:0] inf;
  } vec_t;
  vec_t tbl [10];

  int n_vec = 0, n_err = 0;
  int sent, got, cyc;
  int lhd [4];
  int ltl [4];
  logic [31:0] lbuf [4][64];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst;
    rst = 1'b1;
    step;
    rst = 1'b0;
  endtask

  initial begin
    {s_valid2, m_ready2, flush2, s_data2, lane_ready2, res_valid2, res_data2} = '0;
    {s_valid4, m_ready4, flush4, s_data4, lane_ready4, res_valid4, res_data4} = '0;
    tbl[0] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 5'd0};
    tbl[1] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 5'd1};
    tbl[2] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 5'd2};
    tbl[3] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 5'd3};
    tbl[4] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 5'd4};
    tbl[5] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 5'd4};
    tbl[6] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 5'd5};
    tbl[7] = '{4'b0101, 1'b1, 4'b0100, 1'b1, 5'd5};
    tbl[8] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 5'd6};
    tbl[9] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 5'd7};
    #2;
    chk("rst_busy", busy2, 0);
    chk("rst_m_valid", m_valid2, 0);
    chk("rst_in_flight", in_flight2, 0);
    chk("rst_tri_count", tri_count2, 0);
    chk("rst_flush_done", flush_done2, 0);
    step;
    rst = 1'b0;
    // four triangles alternate lanes, results come back out of order
    s_valid2 = 1; lane_ready2 = 2'b11; s_data2 = TA;
    #1 chk("issue_A", lane_valid2, 2'b01); chk("bcast_A", lane_data2, TA); chk("s_ready_A", s_ready2, 1);
    step; s_data2 = TB;
    #1 chk("issue_B", lane_valid2, 2'b10);
    step; s_data2 = TC;
    #1 chk("issue_C", lane_valid2, 2'b01);
    step; s_data2 = TD;
    #1 chk("issue_D", lane_valid2, 2'b10);
    step; s_valid2 = 0;
    #1 chk("full_in_flight", in_flight2, 4); chk("full_s_ready", s_ready2, 0);
    res_valid2 = 2'b10; res_data2 = {TB, 32'h0}; m_ready2 = 1;
    #1 chk("b_first_held", m_valid2, 0); chk("res_ready_head0", res_ready2, 2'b01);
    step; res_valid2 = 2'b11; res_data2 = {TB, TA};
    #1 chk("out_A_valid", m_valid2, 1); chk("out_A", m_data2, TA);
    step; res_data2 = {TB, TC};
    #1 chk("out_B", m_data2, TB); chk("res_ready_head1", res_ready2, 2'b10);
    step; res_data2 = {TD, TC};
    #1 chk("out_C", m_data2, TC); chk("res_ready_C", res_ready2, 2'b01);
    step; res_valid2 = 2'b10; res_data2 = {TD, 32'h0};
    #1 chk("out_D", m_data2, TD);
    step; res_valid2 = 0; m_ready2 = 0;
    #1 chk("tri_count_4", tri_count2, 4); chk("drained", in_flight2, 0); chk("idle_m_valid", m_valid2, 0);
    // lane 0 busy: issue skips to lane 1 and the pointer wraps back to 0
    s_valid2 = 1; lane_ready2 = 2'b10;
    #1 chk("skip_busy_lane", lane_valid2, 2'b10);
    step; lane_ready2 = 2'b11;
    #1 chk("rr_wrapped", lane_valid2, 2'b01);
    step; s_valid2 = 0; res_valid2 = 2'b10;
    #1 chk("pre_rst_m_valid", m_valid2, 1); chk("pre_rst_busy", busy2, 1); chk("pre_rst_in_flight", in_flight2, 2);
    // asynchronous reset in the middle of a cycle
    rst = 1'b1;
    #1 chk("async_m_valid", m_valid2, 0); chk("async_busy", busy2, 0);
    chk("async_in_flight", in_flight2, 0); chk("async_tri_count", tri_count2, 0);
    step; rst = 1'b0; res_valid2 = 0;
    // order FIFO full: the pop cycle does not also push
    s_valid2 = 1; lane_ready2 = 2'b11;
    for (int k = 0; k < 4; k++) begin
      s_data2 = 32'(k);
      #1 chk("fill_s_ready", s_ready2, 1);
      step;
    end
    #1 chk("fifth_blocked", s_ready2, 0); chk("fifth_in_flight", in_flight2, 4); chk("fifth_no_issue", lane_valid2, 0);
    res_valid2 = 2'b01; m_ready2 = 1;
    #1 chk("pop_m_valid", m_valid2, 1); chk("pop_no_push", s_ready2, 0);
    step; m_ready2 = 0; res_valid2 = 0;
    #1 chk("after_pop_in_flight", in_flight2, 3); chk("after_pop_s_ready", s_ready2, 1);
    step;
    #1 chk("refill_in_flight", in_flight2, 4); chk("refill_s_ready", s_ready2, 0);
    s_valid2 = 0;
    do_rst;
    // flush with three triangles outstanding
    s_valid2 = 1; lane_ready2 = 2'b11;
    repeat (3) step;
    s_valid2 = 0; flush2 = 1;
    #1 chk("flush_in_flight", in_flight2, 3);
    step; flush2 = 0; s_valid2 = 1;
    #1 chk("drain_s_ready", s_ready2, 0); chk("drain_busy", busy2, 1); chk("drain_no_issue", lane_valid2, 0);
    res_valid2 = 2'b11; m_ready2 = 1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("drain_emit", m_valid2, 1); chk("drain_blocked", s_ready2, 0);
      step;
      flush2 = (k == 0);
    end
    flush2 = 0; res_valid2 = 0; m_ready2 = 0;
    #1 chk("drain_empty_busy", busy2, 1); chk("drain_done_early", flush_done2, 0);
    chk("drain_empty_s_ready", s_ready2, 0); chk("drain_empty_in_flight", in_flight2, 0);
    s_valid2 = 0;
    step;
    #1 chk("flush_done_pulse", flush_done2, 1); chk("run_busy", busy2, 0);
    chk("run_s_ready", s_ready2, 1); chk("flush_tri_count", tri_count2, 3);
    step;
    #1 chk("flush_done_single", flush_done2, 0);
    // flush with nothing outstanding
    flush2 = 1;
    #1 chk("empty_flush_busy0", busy2, 0);
    step; flush2 = 0;
    #1 chk("empty_flush_drain", busy2, 1); chk("empty_flush_s_ready", s_ready2, 0); chk("empty_flush_nodone", flush_done2, 0);
    step;
    #1 chk("empty_flush_done", flush_done2, 1); chk("empty_flush_run", busy2, 0);
    step;
    #1 chk("empty_flush_done_end", flush_done2, 0);
    do_rst;
    // four-lane selection table
    for (int i = 0; i < 10; i++) begin
      lane_ready4 = tbl[i].rdy; s_valid4 = tbl[i].sv; s_data4 = 32'(i);
      #1 chk($sformatf("tbl%0d_lane_valid", i), lane_valid4, tbl[i].lv);
      chk($sformatf("tbl%0d_s_ready", i), s_ready4, tbl[i].sr);
      chk($sformatf("tbl%0d_in_flight", i), in_flight4, tbl[i].inf);
      step;
    end
    s_valid4 = 0; lane_ready4 = 0;
    #1 chk("tbl_final_in_flight", in_flight4, 8);
    do_rst;
    // random lane latencies: output order must match input order
    sent = 0; got = 0; cyc = 0;
    for (int i = 0; i < 4; i++) begin lhd[i] = 0; ltl[i] = 0; end
    while (got < 1000 && cyc < 20000) begin
      for (int i = 0; i < 4; i++) begin
        lane_ready4[i] = $urandom_range(0, 3) != 0;
        res_valid4[i] = (lhd[i] != ltl[i]) && ($urandom_range(0, 2) != 0);
        res_data4[i*32 +: 32] = lbuf[i][lhd[i] % 64];
      end
      m_ready4 = $urandom_range(0, 3) != 0;
      s_valid4 = (sent < 1000) && ($urandom_range(0, 3) != 0);
      s_data4 = 32'(sent) ^ 32'h5A00_0000;
      #1;
      if (s_valid4 && s_ready4) begin
        for (int i = 0; i < 4; i++)
          if (lane_valid4[i]) begin
            lbuf[i][ltl[i] % 64] = lane_data4;
            ltl[i]++;
          end
        sent++;
      end
      if (m_valid4 && m_ready4) begin
        chk("rand_order", m_data4, 32'(got) ^ 32'h5A00_0000);
        got++;
      end
      for (int i = 0; i < 4; i++)
        if (res_valid4[i] && res_ready4[i]) lhd[i]++;
      step;
      cyc++;
    end
    {s_valid4, m_ready4, res_valid4, lane_ready4} = '0;
    #1 chk("rand_all_emitted", got, 1000);
    chk("rand_tri_count", tri_count4, 1000);
    chk("rand_in_flight", in_flight4, 0);
    chk("rand_busy", busy4, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
